// File: rtl/cmd_tag_control_pkg.sv
// Shared types for the PSL command tag controller: command metadata, buffer status
// and the tag buffer FSM states.
package cmd_tag_control_pkg;

    localparam int TAG_WIDTH = 8;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic [12:0] command;
        logic [63:0] address;
        logic [11:0] size;
        tag_t        tag;
    } CommandTagLine;

    typedef struct packed {
        logic full;
        logic alfull;
        logic valid;
        logic empty;
    } BufferStatus;

    typedef enum logic [1:0] {
        TAG_BUFFER_RESET,
        TAG_BUFFER_INIT,
        TAG_BUFFER_POP,
        TAG_BUFFER_READY
    } tag_buffer_state;

endpackage

// File: rtl/cmd_tag_control_tag_free_list.sv
// Circular FIFO of free tags with a registered head and an occupancy count.
// The head register tracks mem[rd_ptr] and bypasses a push into the slot being read.
module tag_free_list
    import cmd_tag_control_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  tag_t                       push_tag_i,
    input  logic                       pop_i,
    output tag_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    tag_t          mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    tag_t          head_q, head_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A push landing in the slot about to become head must be forwarded.
        head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? push_tag_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_tag_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/cmd_tag_control.sv
// PSL command tag owner: hands out free tags, records each command's metadata per tag,
// serves registered tag lookups and recycles tags when their response retires.
module cmd_tag_control
    import cmd_tag_control_pkg::*;
#(
    parameter int NUM_TAGS = 256
) (
    input  logic          clock,
    input  logic          rstn,
    input  logic          enabled_in,
    input  logic          alloc_req_in,
    input  CommandTagLine cmd_tag_in,
    output logic          tag_valid_out,
    output tag_t          tag_out,
    input  logic          release_valid_in,
    input  tag_t          release_tag_in,
    input  logic          rsp_lookup_valid_in,
    input  tag_t          rsp_lookup_tag_in,
    output CommandTagLine rsp_cmd_out,
    output logic          rsp_cmd_valid_out,
    input  logic          data_lookup_valid_in,
    input  tag_t          data_lookup_tag_in,
    output CommandTagLine data_cmd_out,
    output logic          data_cmd_valid_out,
    output BufferStatus   tag_status_out,
    output logic [8:0]    outstanding_out,
    output logic          tag_error_out
);

    localparam int IW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int CW = $clog2(NUM_TAGS + 1);

    tag_buffer_state state_q;
    tag_t            init_cnt_q;
    logic [NUM_TAGS-1:0] out_q;
    CommandTagLine   table_q [NUM_TAGS];
    logic [8:0]      out_cnt_q;
    logic            err_q;
    logic            rel_pend_q;
    tag_t            rel_tag_q;
    CommandTagLine   rsp_q, data_q;
    logic            rsp_vld_q, data_vld_q;

    tag_t          fl_head;
    logic [CW-1:0] fl_count;
    logic          fl_push;
    tag_t          fl_push_tag;
    logic          alloc_ok, rel_ok, rel_in_range;
    logic [IW-1:0] rel_idx, head_idx, rsp_idx, data_idx;
    CommandTagLine new_entry;

    function automatic logic in_range(input tag_t t);
        return {1'b0, t} < 9'(NUM_TAGS);
    endfunction

    assign rel_idx  = release_tag_in[IW-1:0];
    assign head_idx = fl_head[IW-1:0];
    assign rsp_idx  = rsp_lookup_tag_in[IW-1:0];
    assign data_idx = data_lookup_tag_in[IW-1:0];

    assign tag_valid_out = (state_q == TAG_BUFFER_READY) && (fl_count != '0);
    assign tag_out       = fl_head;
    assign alloc_ok      = alloc_req_in && tag_valid_out && enabled_in;
    assign rel_in_range  = in_range(release_tag_in);
    assign rel_ok        = release_valid_in && rel_in_range && out_q[rel_idx];

    // Released tags reach the free list one cycle late, so a returned tag is
    // never re-issued sooner than two cycles after its release.
    assign fl_push     = (state_q == TAG_BUFFER_INIT) || rel_pend_q;
    assign fl_push_tag = (state_q == TAG_BUFFER_INIT) ? init_cnt_q : rel_tag_q;

    tag_free_list #(.DEPTH(NUM_TAGS)) u_free_list (
        .clk_i      (clock),
        .rst_ni     (rstn),
        .push_i     (fl_push),
        .push_tag_i (fl_push_tag),
        .pop_i      (alloc_ok),
        .head_o     (fl_head),
        .count_o    (fl_count)
    );

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q    <= TAG_BUFFER_RESET;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                TAG_BUFFER_RESET: begin
                    state_q    <= TAG_BUFFER_INIT;
                    init_cnt_q <= '0;
                end
                TAG_BUFFER_INIT: begin
                    init_cnt_q <= init_cnt_q + 8'd1;
                    if (init_cnt_q == tag_t'(NUM_TAGS - 1)) state_q <= TAG_BUFFER_POP;
                end
                TAG_BUFFER_POP:   state_q <= TAG_BUFFER_READY;
                default:          state_q <= TAG_BUFFER_READY;
            endcase
        end
    end

    always_comb begin
        new_entry     = cmd_tag_in;
        new_entry.tag = fl_head;
    end

    always_ff @(posedge clock) begin
        if (alloc_ok) table_q[head_idx] <= new_entry;
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            out_q      <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
            rel_pend_q <= 1'b0;
            rel_tag_q  <= '0;
        end else begin
            if (rel_ok)   out_q[rel_idx]  <= 1'b0;
            if (alloc_ok) out_q[head_idx] <= 1'b1;
            case ({alloc_ok, rel_ok})
                2'b10:   out_cnt_q <= out_cnt_q + 9'd1;
                2'b01:   out_cnt_q <= out_cnt_q - 9'd1;
                default: out_cnt_q <= out_cnt_q;
            endcase
            if ((alloc_req_in && !alloc_ok) || (release_valid_in && !rel_ok)) err_q <= 1'b1;
            rel_pend_q <= rel_ok;
            rel_tag_q  <= release_tag_in;
        end
    end

    // Lookups read the table before this cycle's write: no alloc bypass.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            rsp_q      <= '0;
            rsp_vld_q  <= 1'b0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_lookup_valid_in;
            data_vld_q <= data_lookup_valid_in;
            if (rsp_lookup_valid_in) begin
                rsp_q     <= in_range(rsp_lookup_tag_in) ? table_q[rsp_idx] : '0;
                rsp_q.tag <= rsp_lookup_tag_in;
            end
            if (data_lookup_valid_in) begin
                data_q     <= in_range(data_lookup_tag_in) ? table_q[data_idx] : '0;
                data_q.tag <= data_lookup_tag_in;
            end
        end
    end

    assign rsp_cmd_out        = rsp_q;
    assign rsp_cmd_valid_out  = rsp_vld_q;
    assign data_cmd_out       = data_q;
    assign data_cmd_valid_out = data_vld_q;
    assign outstanding_out    = out_cnt_q;
    assign tag_error_out      = err_q;

    assign tag_status_out.full   = (out_cnt_q == 9'(NUM_TAGS));
    assign tag_status_out.alfull = ((9'(NUM_TAGS) - out_cnt_q) <= 9'd2);
    assign tag_status_out.valid  = tag_valid_out;
    assign tag_status_out.empty  = (out_cnt_q == 9'd0);

endmodule

// File: tb/tb_cmd_tag_control.sv
// Scenario bench for cmd_tag_control with NUM_TAGS=4: a free-list model and lookup
// scoreboards predict every issued tag and every lookup result.
module tb_cmd_tag_control;
    import cmd_tag_control_pkg::*;

    localparam int NT = 4;

    logic          clock = 1'b0;
    logic          rstn;
    logic          enabled_in;
    logic          alloc_req_in;
    CommandTagLine cmd_tag_in;
    logic          tag_valid_out;
    tag_t          tag_out;
    logic          release_valid_in;
    tag_t          release_tag_in;
    logic          rsp_lookup_valid_in;
    tag_t          rsp_lookup_tag_in;
    CommandTagLine rsp_cmd_out;
    logic          rsp_cmd_valid_out;
    logic          data_lookup_valid_in;
    tag_t          data_lookup_tag_in;
    CommandTagLine data_cmd_out;
    logic          data_cmd_valid_out;
    BufferStatus   tag_status_out;
    logic [8:0]    outstanding_out;
    logic          tag_error_out;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            model_out;
    tag_t          model_free[$];
    CommandTagLine model_tbl[NT];
    CommandTagLine rsp_sb[$];
    CommandTagLine data_sb[$];

    always #5 clock = ~clock;

    cmd_tag_control #(.NUM_TAGS(NT)) dut (
        .clock                (clock),
        .rstn                 (rstn),
        .enabled_in           (enabled_in),
        .alloc_req_in         (alloc_req_in),
        .cmd_tag_in           (cmd_tag_in),
        .tag_valid_out        (tag_valid_out),
        .tag_out              (tag_out),
        .release_valid_in     (release_valid_in),
        .release_tag_in       (release_tag_in),
        .rsp_lookup_valid_in  (rsp_lookup_valid_in),
        .rsp_lookup_tag_in    (rsp_lookup_tag_in),
        .rsp_cmd_out          (rsp_cmd_out),
        .rsp_cmd_valid_out    (rsp_cmd_valid_out),
        .data_lookup_valid_in (data_lookup_valid_in),
        .data_lookup_tag_in   (data_lookup_tag_in),
        .data_cmd_out         (data_cmd_out),
        .data_cmd_valid_out   (data_cmd_valid_out),
        .tag_status_out       (tag_status_out),
        .outstanding_out      (outstanding_out),
        .tag_error_out        (tag_error_out)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic CommandTagLine rand_cmd();
        CommandTagLine c;
        c.command = 13'($urandom);
        c.address = {$urandom, $urandom};
        c.size    = 12'($urandom);
        c.tag     = 8'hA5;
        return c;
    endfunction

    task automatic drive_alloc(input CommandTagLine c, output logic v, output tag_t got);
        alloc_req_in = 1'b1;
        cmd_tag_in   = c;
        v            = tag_valid_out;
        got          = tag_out;
        step();
        alloc_req_in = 1'b0;
    endtask

    task automatic drive_release(input tag_t t);
        release_valid_in = 1'b1;
        release_tag_in   = t;
        step();
        release_valid_in = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        rstn = 1'b1;
        cyc  = 0;
        while (!tag_valid_out && cyc < 50) begin
            step();
            cyc++;
        end
        model_free.delete();
        for (int i = 0; i < NT; i++) model_free.push_back(tag_t'(i));
        model_out = 0;
    endtask

    task automatic test_reset();
        int cyc;
        rstn = 1'b0; enabled_in = 1'b1; alloc_req_in = 1'b0; cmd_tag_in = '0;
        release_valid_in = 1'b0; release_tag_in = '0;
        rsp_lookup_valid_in = 1'b0; rsp_lookup_tag_in = '0;
        data_lookup_valid_in = 1'b0; data_lookup_tag_in = '0;
        step(); step();
        n_tests++;
        if ({tag_valid_out, outstanding_out, tag_error_out, rsp_cmd_valid_out, data_cmd_valid_out} !== 13'd0
            || tag_status_out !== BufferStatus'(4'b0001) || rsp_cmd_out !== '0 || data_cmd_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b out=%0d err=%0b status=%b expected all 0, status 0001",
                     tag_valid_out, outstanding_out, tag_error_out, tag_status_out);
        end
        wait_ready(cyc);
        n_tests++;
        if (cyc !== 6) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d cycles expected 6", cyc);
        end
        n_tests++;
        if (tag_out !== 8'd0 || tag_status_out.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tag: tag=%0d empty=%0b expected tag=0 empty=1", tag_out, tag_status_out.empty);
        end
    endtask

    task automatic test_drain();
        CommandTagLine c;
        logic v;
        tag_t got, exp;
        for (int i = 0; i < NT; i++) begin
            c = rand_cmd();
            drive_alloc(c, v, got);
            exp = model_free.pop_front();
            n_tests++;
            if (v !== 1'b1 || got !== exp) begin
                n_fail++;
                $display("FAIL drain_alloc: valid=%0b tag=%0d expected valid=1 tag=%0d", v, got, exp);
            end
            c.tag = exp;
            model_tbl[exp] = c;
            model_out++;
        end
        n_tests++;
        if (tag_valid_out !== 1'b0 || tag_status_out !== BufferStatus'(4'b1100) || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL drain_full: valid=%0b status=%b out=%0d expected 0, 1100, %0d",
                     tag_valid_out, tag_status_out, outstanding_out, model_out);
        end
        data_lookup_valid_in = 1'b1; data_lookup_tag_in = 8'd1;
        data_sb.push_back(model_tbl[1]);
        step();
        data_lookup_valid_in = 1'b0;
        n_tests++;
        if (!data_cmd_valid_out) begin
            n_fail++;
            $display("FAIL data_lookup_valid: got 0 expected 1");
        end else begin
            c = data_sb.pop_front();
            if (data_cmd_out !== c) begin
                n_fail++;
                $display("FAIL data_lookup: got %h expected %h", data_cmd_out, c);
            end
        end
    endtask

    task automatic test_release_realloc();
        CommandTagLine c;
        logic v;
        tag_t got, exp;
        drive_release(8'd2);
        model_free.push_back(8'd2);
        model_out--;
        n_tests++;
        if (tag_valid_out !== 1'b0 || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL release_early: valid=%0b out=%0d expected 0, %0d", tag_valid_out, outstanding_out, model_out);
        end
        step();
        c = rand_cmd();
        drive_alloc(c, v, got);
        exp = model_free.pop_front();
        n_tests++;
        if (v !== 1'b1 || got !== exp) begin
            n_fail++;
            $display("FAIL realloc: valid=%0b tag=%0d expected valid=1 tag=%0d", v, got, exp);
        end
        c.tag = exp;
        model_tbl[exp] = c;
        model_out++;
        rsp_lookup_valid_in = 1'b1; rsp_lookup_tag_in = 8'd2;
        rsp_sb.push_back(model_tbl[2]);
        step();
        rsp_lookup_valid_in = 1'b0;
        n_tests++;
        if (!rsp_cmd_valid_out) begin
            n_fail++;
            $display("FAIL rsp_lookup_valid: got 0 expected 1");
        end else begin
            c = rsp_sb.pop_front();
            if (rsp_cmd_out !== c) begin
                n_fail++;
                $display("FAIL rsp_lookup_new: got %h expected %h", rsp_cmd_out, c);
            end
        end
    endtask

    task automatic test_back_to_back();
        CommandTagLine c, e;
        logic v;
        tag_t got, exp;
        drive_release(8'd1);
        drive_release(8'd3);
        model_free.push_back(8'd1);
        model_free.push_back(8'd3);
        model_out -= 2;
        // Same cycle: allocate tag 1, release tag 0, look up both (pre-update entries).
        release_valid_in = 1'b1; release_tag_in = 8'd0;
        rsp_lookup_valid_in = 1'b1; rsp_lookup_tag_in = 8'd1;
        data_lookup_valid_in = 1'b1; data_lookup_tag_in = 8'd0;
        rsp_sb.push_back(model_tbl[1]);
        data_sb.push_back(model_tbl[0]);
        c = rand_cmd();
        drive_alloc(c, v, got);
        release_valid_in = 1'b0; rsp_lookup_valid_in = 1'b0; data_lookup_valid_in = 1'b0;
        exp = model_free.pop_front();
        model_free.push_back(8'd0);
        c.tag = exp;
        model_tbl[exp] = c;
        n_tests++;
        if (v !== 1'b1 || got !== exp || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL simul_alloc_release: valid=%0b tag=%0d out=%0d expected 1, %0d, %0d",
                     v, got, outstanding_out, exp, model_out);
        end
        n_tests++;
        e = rsp_sb.pop_front();
        if (rsp_cmd_valid_out !== 1'b1 || rsp_cmd_out !== e) begin
            n_fail++;
            $display("FAIL lookup_no_bypass: got %h expected %h", rsp_cmd_out, e);
        end
        n_tests++;
        e = data_sb.pop_front();
        if (data_cmd_valid_out !== 1'b1 || data_cmd_out !== e) begin
            n_fail++;
            $display("FAIL lookup_pre_release: got %h expected %h", data_cmd_out, e);
        end
    endtask

    task automatic test_bad_release();
        CommandTagLine c;
        logic v;
        tag_t got, exp;
        drive_release(8'd3);
        n_tests++;
        if (tag_error_out !== 1'b1 || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL bad_release: err=%0b out=%0d expected 1, %0d", tag_error_out, outstanding_out, model_out);
        end
        step(); step();
        n_tests++;
        if (tag_error_out !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: got %0b expected 1", tag_error_out);
        end
        while (model_free.size() > 0) begin
            c = rand_cmd();
            drive_alloc(c, v, got);
            exp = model_free.pop_front();
            n_tests++;
            if (v !== 1'b1 || got !== exp) begin
                n_fail++;
                $display("FAIL free_list_order: valid=%0b tag=%0d expected valid=1 tag=%0d", v, got, exp);
            end
            c.tag = exp;
            model_tbl[exp] = c;
            model_out++;
        end
        n_tests++;
        if (tag_valid_out !== 1'b0 || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL free_list_unchanged: valid=%0b out=%0d expected 0, %0d", tag_valid_out, outstanding_out, model_out);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        drive_release(8'd2);
        model_out--;
        step();
        n_tests++;
        if (outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d expected %0d", outstanding_out, model_out);
        end
        rstn = 1'b0;
        step();
        n_tests++;
        if (outstanding_out !== 9'd0 || tag_error_out !== 1'b0 || tag_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: out=%0d err=%0b valid=%0b expected 0, 0, 0", outstanding_out, tag_error_out, tag_valid_out);
        end
        wait_ready(cyc);
        n_tests++;
        if (cyc !== 6 || tag_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reinit: cycles=%0d tag=%0d expected 6, 0", cyc, tag_out);
        end
    endtask

    task automatic test_bad_alloc();
        CommandTagLine c;
        logic v;
        tag_t got, exp;
        enabled_in = 1'b0;
        c = rand_cmd();
        drive_alloc(c, v, got);
        enabled_in = 1'b1;
        n_tests++;
        if (tag_error_out !== 1'b1 || outstanding_out !== 9'd0 || tag_valid_out !== 1'b1 || tag_out !== 8'd0) begin
            n_fail++;
            $display("FAIL disabled_alloc: err=%0b out=%0d valid=%0b tag=%0d expected 1, 0, 1, 0",
                     tag_error_out, outstanding_out, tag_valid_out, tag_out);
        end
        drive_alloc(c, v, got);
        exp = model_free.pop_front();
        model_out++;
        n_tests++;
        if (got !== exp || outstanding_out !== 9'(model_out)) begin
            n_fail++;
            $display("FAIL enabled_alloc: tag=%0d out=%0d expected %0d, %0d", got, outstanding_out, exp, model_out);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_release_realloc();
        test_back_to_back();
        test_bad_release();
        test_mid_reset();
        test_bad_alloc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
